// File: rtl/mcu0_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian 16-bit words written to the mcu0 memory, then CPU release.
// Optional trailing 8-bit checksum check is built when LOADER_CHECKSUM_EN is defined.

// state    | meaning
// S_LEN_HI | waiting for word-count high nibble byte
// S_LEN_LO | waiting for word-count low byte
// S_DAT_HI | waiting for high byte of next word
// S_DAT_LO | waiting for low byte of next word
// S_WRITE  | one-cycle memory write strobe, input stalled
// S_CHK    | waiting for checksum byte (checksum builds only)
// S_DONE   | load complete, CPU running
// S_ERR    | checksum mismatch, CPU held (checksum builds only)
module mcu0_loader #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_w,
  output logic [AW-1:0] mem_wi,
  output logic [15:0]   mem_wd,
  output logic          cpu_run,
  output logic          err
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WRITE,
    S_DONE
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
    , S_ERR
`endif
  } state_t;

  // where the stream goes once all words are written
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  len_hi;
  logic [11:0] count;
  logic        xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign xfer = in_valid & in_ready;

  function automatic logic ready_of(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: r = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:                                  r = 1'b1;
`endif
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) state_nxt = ({len_hi, in_data} == 12'd0) ? S_FINAL : S_DAT_HI;
      S_DAT_HI: if (xfer) state_nxt = S_DAT_LO;
      S_DAT_LO: if (xfer) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (count == 12'd1) ? S_FINAL : S_DAT_HI;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:    if (xfer) state_nxt = (in_data == sum) ? S_DONE : S_ERR;
`endif
      default:  state_nxt = state;
    endcase
  end

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_LEN_HI;
      in_ready <= 1'b1;
      mem_w    <= 1'b0;
      cpu_run  <= 1'b0;
      mem_wi   <= '0;
      mem_wd   <= 16'd0;
      len_hi   <= 4'd0;
      count    <= 12'd0;
    end else begin
      state    <= state_nxt;
      in_ready <= ready_of(state_nxt);
      mem_w    <= (state_nxt == S_WRITE);
      cpu_run  <= (state_nxt == S_DONE);
      case (state)
        S_LEN_HI: if (xfer) len_hi <= in_data[3:0];
        S_LEN_LO: if (xfer) count <= {len_hi, in_data};
        S_DAT_HI: if (xfer) mem_wd[15:8] <= in_data;
        S_DAT_LO: if (xfer) mem_wd[7:0] <= in_data;
        S_WRITE: begin
          mem_wi <= mem_wi + AW'(2);
          count  <= count - 12'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= 8'd0;
      err <= 1'b0;
    end else begin
      err <= (state_nxt == S_ERR);
      if (xfer && state != S_CHK) sum <= sum + in_data;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mcu0_loader.md
# mcu0_loader

Boot loader that sits directly upstream of the mcu0 program/data memory. It receives a byte stream over a valid/ready interface, assembles big-endian 16-bit words, and writes them to consecutive even byte addresses starting at 0. It then releases the CPU by asserting `cpu_run`. The memory write port it drives is the level-sensitive `w/wi/wd` port of the mcu0 memory.

## Interface
- `AW`, 12, byte-address width of target memory.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; transfer = `in_valid & in_ready` at the rising edge.
- `mem_w`  out  1  memory write strobe, one-cycle pulse.
- `mem_wi`  out  AW  byte address of the word being written (always even).
- `mem_wd`  out  16  word data, {high byte, low byte}.
- `cpu_run`  out  1  load complete; CPU may fetch.
- `err`  out  1  checksum failure (only with `LOADER_CHECKSUM_EN`; otherwise constant 0).

## Operation
- Stream format: `LEN_HI`, `LEN_LO` (word count N = {LEN_HI[3:0], LEN_LO}, 12 bits; LEN_HI[7:4] ignored), then 2N data bytes, high byte first. With `LOADER_CHECKSUM_EN`, one trailing checksum byte follows.
- States:
  - `S_LEN_HI`: accept byte, store; go to `S_LEN_LO`.
  - `S_LEN_LO`: accept byte; if N==0 go to `S_CHK` (checksum build) or `S_DONE`; else go to `S_DAT_HI`.
  - `S_DAT_HI`: accept byte into `mem_wd[15:8]`; go to `S_DAT_LO`.
  - `S_DAT_LO`: accept byte into `mem_wd[7:0]`; go to `S_WRITE`.
  - `S_WRITE`: `mem_w`=1 for exactly this cycle; `in_ready`=0. On exit, `mem_wi` += 2 (mod 2^AW) and the remaining count is decremented; go to `S_DAT_HI` if the count is nonzero, else `S_CHK` or `S_DONE`.
  - `S_CHK` (checksum builds only): accept byte; go to `S_DONE` if it equals the running sum, else `S_ERR`.
  - `S_DONE`: `cpu_run`=1, `in_ready`=0; terminal until reset.
  - `S_ERR`: `err`=1, `cpu_run`=0, `in_ready`=0; terminal until reset.
- `in_ready`=1 exactly in `S_LEN_HI`, `S_LEN_LO`, `S_DAT_HI`, `S_DAT_LO` and `S_CHK`. A state without a transfer holds all registers.
- Address wraps modulo 2^AW. For N > 2^(AW-1), later words overwrite from address 0; this is not an error.
- Reset values: state `S_LEN_HI`; `mem_wi`=0; `mem_wd`=0; count=0; sum=0; `mem_w`=0; `cpu_run`=0; `err`=0; `in_ready`=1.
- Reset mid-load returns to `S_LEN_HI` with address 0. Memory contents already written are not cleared.

## Timing
- All outputs are registered or decoded from the state register only; there is no combinational path from `in_valid`/`in_data` to any output.
- `mem_wi` and `mem_wd` are stable from the edge entering `S_WRITE` through the edge leaving it. The pulse does not overlap any address or data change.
- Per word: minimum 3 cycles (hi, lo, write). Load throughput is 2 bytes per 3 cycles.
- `cpu_run` rises on the edge after the last accepted byte when N==0 or checksum is used, and on the edge after the final `S_WRITE` otherwise.
- `in_valid` may drop at any time; it stalls without loss.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) accumulates every accepted byte, including `LEN_HI` and `LEN_LO`.
  - The trailing byte must equal the sum; on mismatch the block enters `S_ERR` and `err`=1.
- `LOADER_CHECKSUM_EN` undefined:
  - No `S_CHK` or `S_ERR` state and no sum register.
  - `err` is tied to 0, and `cpu_run` rises immediately after the last write.

## Test plan
- Reset, then stream 00 02 12 34 AB CD with `in_valid` held high -> writes (0x000, 0x1234) then (0x002, 0xABCD). Each `mem_w` is 1 cycle, `in_ready`=0 during writes, and `cpu_run`=1 afterwards.
- Stream 00 00 (and checksum 00 when enabled) -> no `mem_w` pulse; `cpu_run`=1.
- Same 2-word stream with `in_valid` toggled randomly, including gaps mid-word -> identical writes; no byte is dropped or duplicated.
- Assert `reset` after the first word is written, then load 00 01 55 AA -> write (0x000, 0x55AA); no write ever reaches address 0x002.
- Checksum build, stream 00 01 12 34 47 -> `cpu_run`=1. Stream 00 01 12 34 48 -> `err`=1, `cpu_run`=0, `in_ready`=0.
- AW=4 with N=9 -> the 9th word is written at address 0x0 (wrap); `cpu_run`=1.
